// File: rtl/pu_riscv_ahb_wbuf_drain.sv
// -----------------------------------------------------------------------------
// pu_riscv_ahb_wbuf_drain
//
// Read side of the store/write-buffer fall-through queue. Pops queued write
// entries and issues each one as a single NONSEQ AHB-Lite write transfer.
// Address and data phases are pipelined: while one entry is in its data phase
// the next may be in its address phase, which gives one transfer per cycle at
// zero wait states.
//
// Ports:
//   rst_ni, clk_i        asynchronous active-low reset, rising-edge clock
//   clr_i                synchronous clear: drops in-flight state, clears err_o
//   q_empty_i            write queue empty
//   q_adr_i/q_size_i/q_data_i  head entry (fall-through, valid when !q_empty_i)
//   q_re_o               queue pop, one-cycle pulse (combinational)
//   HSEL..HMASTLOCK      AHB-Lite master outputs (all registered)
//   HREADY, HRESP        AHB-Lite slave response
//   busy_o               an address or data phase is outstanding
//   err_o                sticky bus error, cleared only by clr_i or reset
// -----------------------------------------------------------------------------
module pu_riscv_ahb_wbuf_drain #(
    parameter int PLEN = 64,
    parameter int XLEN = 64
) (
    input  logic            rst_ni,
    input  logic            clk_i,
    input  logic            clr_i,

    input  logic            q_empty_i,
    input  logic [PLEN-1:0] q_adr_i,
    input  logic [2:0]      q_size_i,
    input  logic [XLEN-1:0] q_data_i,
    output logic            q_re_o,

    output logic            HSEL,
    output logic [PLEN-1:0] HADDR,
    output logic [XLEN-1:0] HWDATA,
    output logic            HWRITE,
    output logic [2:0]      HSIZE,
    output logic [2:0]      HBURST,
    output logic [3:0]      HPROT,
    output logic [1:0]      HTRANS,
    output logic            HMASTLOCK,
    input  logic            HREADY,
    input  logic            HRESP,

    output logic            busy_o,
    output logic            err_o
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    // data access, privileged
    localparam logic [3:0] HPROT_DATA    = 4'b0011;

    // Pipeline state
    logic            r_ap_v;        // address phase on the bus
    logic            r_dp_v;        // data phase on the bus
    logic            r_err;         // sticky error
    logic [XLEN-1:0] r_pend_data;   // data for the entry in its address phase

    logic            w_ap_free;
    logic            w_err_first;
    logic            w_err_hit;
    logic            w_issue;
    logic            w_ap_v_nxt;
    logic            w_dp_v_nxt;
    logic            w_err_nxt;

    // The address slot can take a new entry when it is empty or its current
    // occupant is accepted this edge. The first cycle of an ERROR response
    // (HREADY low) cancels the pending address phase, so nothing may be issued
    // into it.
    assign w_ap_free   = ~r_ap_v | HREADY;
    assign w_err_hit   = r_dp_v & HRESP;
    assign w_err_first = w_err_hit & ~HREADY;
    assign w_issue     = w_ap_free & ~q_empty_i & ~r_err & ~clr_i & ~w_err_first;

    // Pop happens in the cycle the head entry is captured; held off in reset.
    assign q_re_o = w_issue & rst_ni;
    assign err_o  = r_err;

    // Next-state computation for the phase-valid flags and the error flag.
    always_comb begin
        w_ap_v_nxt = r_ap_v;
        w_dp_v_nxt = r_dp_v;
        w_err_nxt  = r_err;
        if (clr_i) begin
            w_ap_v_nxt = 1'b0;
            w_dp_v_nxt = 1'b0;
            w_err_nxt  = 1'b0;
        end else begin
            if (w_err_first) begin
                w_ap_v_nxt = 1'b0;
            end else if (w_issue) begin
                w_ap_v_nxt = 1'b1;
            end else if (HREADY) begin
                w_ap_v_nxt = 1'b0;
            end else begin
                w_ap_v_nxt = r_ap_v;
            end

            // On HREADY the current data phase ends and an accepted address
            // phase (if any) becomes the new data phase.
            if (HREADY) begin
                w_dp_v_nxt = r_ap_v;
            end else begin
                w_dp_v_nxt = r_dp_v;
            end

            if (w_err_hit) begin
                w_err_nxt = 1'b1;
            end else begin
                w_err_nxt = r_err;
            end
        end
    end

    // State, bus and status registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ap_v      <= 1'b0;
            r_dp_v      <= 1'b0;
            r_err       <= 1'b0;
            r_pend_data <= {XLEN{1'b0}};
            busy_o      <= 1'b0;
            HSEL        <= 1'b0;
            HADDR       <= {PLEN{1'b0}};
            HWDATA      <= {XLEN{1'b0}};
            HWRITE      <= 1'b1;
            HSIZE       <= 3'b000;
            HBURST      <= HBURST_SINGLE;
            HPROT       <= HPROT_DATA;
            HTRANS      <= HTRANS_IDLE;
            HMASTLOCK   <= 1'b0;
        end else begin
            r_ap_v    <= w_ap_v_nxt;
            r_dp_v    <= w_dp_v_nxt;
            r_err     <= w_err_nxt;
            busy_o    <= w_ap_v_nxt | w_dp_v_nxt;
            HSEL      <= w_ap_v_nxt;
            HTRANS    <= w_ap_v_nxt ? HTRANS_NONSEQ : HTRANS_IDLE;
            HWRITE    <= 1'b1;
            HBURST    <= HBURST_SINGLE;
            HPROT     <= HPROT_DATA;
            HMASTLOCK <= 1'b0;

            if (w_issue) begin
                HADDR       <= q_adr_i;
                HSIZE       <= q_size_i;
                r_pend_data <= q_data_i;
            end

            // Accepted address phase: its data goes onto the bus. This reads
            // the old pending data while a back-to-back issue refills it.
            if (r_ap_v && HREADY && !clr_i) begin
                HWDATA <= r_pend_data;
            end
        end
    end

endmodule

// File: tb/tb_pu_riscv_ahb_wbuf_drain.sv
// -----------------------------------------------------------------------------
// Testbench for pu_riscv_ahb_wbuf_drain.
// The bench owns the write queue (wq) that feeds the DUT. Every entry pushed
// with scoring enabled is also appended to exp_q; a negedge monitor pops exp_q
// whenever an address phase is accepted on the bus and checks the following
// data phase. Directed sequences add cycle-exact latency/error/clear checks.
// -----------------------------------------------------------------------------
module tb_pu_riscv_ahb_wbuf_drain;

    localparam int PLEN = 64;
    localparam int XLEN = 64;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            clr_i;
    logic            q_empty_i;
    logic [PLEN-1:0] q_adr_i;
    logic [2:0]      q_size_i;
    logic [XLEN-1:0] q_data_i;
    logic            q_re_o;
    logic            HSEL;
    logic [PLEN-1:0] HADDR;
    logic [XLEN-1:0] HWDATA;
    logic            HWRITE;
    logic [2:0]      HSIZE;
    logic [2:0]      HBURST;
    logic [3:0]      HPROT;
    logic [1:0]      HTRANS;
    logic            HMASTLOCK;
    logic            HREADY;
    logic            HRESP;
    logic            busy_o;
    logic            err_o;

    pu_riscv_ahb_wbuf_drain #(.PLEN(PLEN), .XLEN(XLEN)) dut (
        .rst_ni(rst_ni), .clk_i(clk_i), .clr_i(clr_i),
        .q_empty_i(q_empty_i), .q_adr_i(q_adr_i), .q_size_i(q_size_i),
        .q_data_i(q_data_i), .q_re_o(q_re_o),
        .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
        .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HRESP(HRESP),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [63:0] adr;
        logic [2:0]  size;
        logic [63:0] data;
    } ent_t;

    ent_t wq[$];      // write queue seen by the DUT
    ent_t exp_q[$];   // transfers expected on the bus, in order

    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 1'b0;
    bit   pop_flag = 1'b0;
    int   pop_cnt = 0;
    bit   mon_dp_act = 1'b0;
    logic [63:0] mon_dp_exp;
    bit   prev_wait = 1'b0;
    logic [63:0] prev_adr;
    ent_t mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_q();
        if (wq.size() == 0) begin
            q_empty_i = 1'b1;
            q_adr_i   = 64'd0;
            q_size_i  = 3'd0;
            q_data_i  = 64'd0;
        end else begin
            q_empty_i = 1'b0;
            q_adr_i   = wq[0].adr;
            q_size_i  = wq[0].size;
            q_data_i  = wq[0].data;
        end
    endtask

    task automatic push(input logic [63:0] a, input logic [2:0] s, input logic [63:0] d, input bit score);
        ent_t e;
        e.adr = a; e.size = s; e.data = d;
        wq.push_back(e);
        if (score) exp_q.push_back(e);
        drive_q();
    endtask

    // Advance one cycle; a pop seen at the previous negedge removes the head.
    task automatic step();
        @(posedge clk_i);
        #1;
        if (pop_flag && wq.size() > 0) void'(wq.pop_front());
        drive_q();
    endtask

    // Scoreboard monitor
    always @(negedge clk_i) begin
        pop_flag = q_re_o;
        if (q_re_o) pop_cnt++;
        if (rst_ni && mon_en) begin
            chk("pop_on_empty", {63'd0, q_re_o & q_empty_i}, 64'd0);
            if (prev_wait) begin
                chk("wait_hold_htrans", {62'd0, HTRANS}, 64'd2);
                chk("wait_hold_haddr", HADDR, prev_adr);
            end
            if (mon_dp_act && HREADY) begin
                chk("sb_hwdata", HWDATA, mon_dp_exp);
                mon_dp_act = 1'b0;
            end
            if (HTRANS == 2'b10 && HREADY) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_xfer", 64'(exp_q.size()), 64'd1);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("sb_haddr", HADDR, mon_e.adr);
                    chk("sb_hsize", {61'd0, HSIZE}, {61'd0, mon_e.size});
                    chk("sb_hwrite_hsel", {62'd0, HWRITE, HSEL}, 64'd3);
                    mon_dp_act = 1'b1;
                    mon_dp_exp = mon_e.data;
                end
            end
            prev_wait = (HTRANS == 2'b10) && !HREADY;
            prev_adr  = HADDR;
        end else begin
            mon_dp_act = 1'b0;
            prev_wait  = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d[4];
        int p0;
        int npush;
        int n;

        rst_ni = 1'b0; clr_i = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
        drive_q();
        repeat (3) @(posedge clk_i);

        // Reset values
        @(negedge clk_i);
        chk("rst_htrans", {62'd0, HTRANS}, 64'd0);
        chk("rst_hsel", {63'd0, HSEL}, 64'd0);
        chk("rst_haddr", HADDR, 64'd0);
        chk("rst_hwdata", HWDATA, 64'd0);
        chk("rst_hwrite", {63'd0, HWRITE}, 64'd1);
        chk("rst_hsize", {61'd0, HSIZE}, 64'd0);
        chk("rst_hburst", {61'd0, HBURST}, 64'd0);
        chk("rst_hprot", {60'd0, HPROT}, 64'd3);
        chk("rst_hmastlock", {63'd0, HMASTLOCK}, 64'd0);
        chk("rst_busy", {63'd0, busy_o}, 64'd0);
        chk("rst_err", {63'd0, err_o}, 64'd0);
        chk("rst_q_re", {63'd0, q_re_o}, 64'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1; mon_en = 1'b1;
        step(); step();

        // Single write with latency
        p0 = pop_cnt;
        push(64'h1000, 3'd3, 64'hDEADBEEF_CAFEF00D, 1'b1);
        @(negedge clk_i);
        chk("single_q_re", {63'd0, q_re_o}, 64'd1);
        step(); @(negedge clk_i);
        chk("single_htrans", {62'd0, HTRANS}, 64'd2);
        chk("single_haddr", HADDR, 64'h1000);
        chk("single_busy1", {63'd0, busy_o}, 64'd1);
        step(); @(negedge clk_i);
        chk("single_hwdata", HWDATA, 64'hDEADBEEF_CAFEF00D);
        chk("single_idle", {62'd0, HTRANS}, 64'd0);
        chk("single_busy2", {63'd0, busy_o}, 64'd1);
        step(); @(negedge clk_i);
        chk("single_busy_drop", {63'd0, busy_o}, 64'd0);
        step();
        chk("single_pops", 64'(pop_cnt - p0), 64'd1);

        // Back-to-back
        p0 = pop_cnt;
        for (int k = 0; k < 4; k++) begin
            d[k] = {$urandom, $urandom};
            push(64'(k * 8), 3'd3, d[k], 1'b1);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_i);
            if (k >= 1 && k <= 4) begin
                chk("b2b_htrans", {62'd0, HTRANS}, 64'd2);
                chk("b2b_haddr", HADDR, 64'((k - 1) * 8));
            end
            if (k >= 2) chk("b2b_hwdata", HWDATA, d[k - 2]);
            step();
        end
        chk("b2b_pops", 64'(pop_cnt - p0), 64'd4);
        step();

        // Wait states in the first data phase
        p0 = pop_cnt;
        d[0] = {$urandom, $urandom};
        d[1] = {$urandom, $urandom};
        push(64'h0, 3'd3, d[0], 1'b1);
        push(64'h8, 3'd3, d[1], 1'b1);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk_i);
            if (k >= 2 && k <= 5) begin
                chk("ws_haddr", HADDR, 64'h8);
                chk("ws_htrans", {62'd0, HTRANS}, 64'd2);
                chk("ws_hwdata", HWDATA, d[0]);
            end
            if (k >= 2 && k <= 4) chk("ws_no_pop", {63'd0, q_re_o}, 64'd0);
            if (k == 6) chk("ws_hwdata2", HWDATA, d[1]);
            step();
            HREADY = (k + 1 >= 2 && k + 1 <= 4) ? 1'b0 : 1'b1;
        end
        chk("ws_pops", 64'(pop_cnt - p0), 64'd2);
        HREADY = 1'b1;
        repeat (2) step();

        // Error on the first data phase
        mon_en = 1'b0;
        p0 = pop_cnt;
        push(64'h200, 3'd3, 64'h1111, 1'b0);
        push(64'h208, 3'd3, 64'h2222, 1'b0);
        push(64'h210, 3'd2, 64'h3333, 1'b0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_i);
            if (k == 3) begin
                chk("err_idle", {62'd0, HTRANS}, 64'd0);
                chk("err_hsel", {63'd0, HSEL}, 64'd0);
            end
            if (k >= 3) begin
                chk("err_sticky", {63'd0, err_o}, 64'd1);
                chk("err_no_pop", {63'd0, q_re_o}, 64'd0);
            end
            if (k >= 4) chk("err_no_nonseq", {62'd0, HTRANS}, 64'd0);
            step();
            HREADY = (k + 1 == 2) ? 1'b0 : 1'b1;
            HRESP  = (k + 1 == 2 || k + 1 == 3) ? 1'b1 : 1'b0;
        end
        chk("err_pops", 64'(pop_cnt - p0), 64'd2);
        chk("err_remaining", 64'(wq.size()), 64'd1);
        chk("err_busy", {63'd0, busy_o}, 64'd0);

        // Clear after error: remaining entry is issued afterwards
        exp_q.delete();
        exp_q.push_back(wq[0]);
        mon_en = 1'b1;
        clr_i = 1'b1;
        @(negedge clk_i);
        chk("clr_no_pop", {63'd0, q_re_o}, 64'd0);
        step();
        clr_i = 1'b0;
        @(negedge clk_i);
        chk("clr_err_clear", {63'd0, err_o}, 64'd0);
        chk("clr_issue_pop", {63'd0, q_re_o}, 64'd1);
        step(); @(negedge clk_i);
        chk("clr_htrans", {62'd0, HTRANS}, 64'd2);
        chk("clr_haddr", HADDR, 64'h210);
        repeat (4) step();
        chk("clr_sb_empty", 64'(exp_q.size()), 64'd0);

        // Randomized traffic with wait states
        p0 = pop_cnt;
        npush = 0;
        for (int c = 0; c < 400; c++) begin
            step();
            if ($urandom_range(0, 2) == 0 && wq.size() < 8) begin
                push({$urandom, $urandom}, 3'($urandom_range(0, 3)), {$urandom, $urandom}, 1'b1);
                npush++;
            end
            HREADY = ($urandom_range(0, 3) != 0);
        end
        HREADY = 1'b1;
        n = 0;
        while ((wq.size() != 0 || busy_o) && n < 100) begin
            step();
            n++;
        end
        chk("rnd_drained_busy", {63'd0, busy_o}, 64'd0);
        chk("rnd_drained_q", 64'(wq.size()), 64'd0);
        chk("rnd_sb_empty", 64'(exp_q.size()), 64'd0);
        chk("rnd_pops", 64'(pop_cnt - p0), 64'(npush));

        // Asynchronous reset in the middle of a burst
        mon_en = 1'b0;
        for (int k = 0; k < 4; k++) push(64'(64'h400 + k * 8), 3'd3, {$urandom, $urandom}, 1'b0);
        step(); step();
        #2;
        chk("mid_pre_nonseq", {62'd0, HTRANS}, 64'd2);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_htrans", {62'd0, HTRANS}, 64'd0);
        chk("mid_rst_hsel", {63'd0, HSEL}, 64'd0);
        chk("mid_rst_busy", {63'd0, busy_o}, 64'd0);
        chk("mid_rst_err", {63'd0, err_o}, 64'd0);
        chk("mid_rst_haddr", HADDR, 64'd0);
        wq.delete();
        drive_q();
        step();
        rst_ni = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
